stream_match_ctrl: RTL and testbench
====================================

// Module: stream_match_ctrl
// PURPOSE
//  Accepts parallel words over a valid/ready handshake and streams them MSB-first, one bit
//  per clock, into an internal Moore pattern detector. Counts overlapping pattern matches per
//  word and pulses done when the word's last bit has been evaluated. Sits between the word
//  source and the string-recognition result logic.
//
// PARAMETERS
//  WORD_W   8        bits per input word
//  PAT_W    4        pattern length in bits (2..WORD_W)
//  PATTERN  4'b0010  target pattern; MSB is the oldest bit
//  CNT_W    4        width of per-word match counter (saturating)
//
// PORTS
//  clock        in   1       clock
//  reset        in   1       asynchronous, active-high
//  in_valid     in   1       in_word is valid
//  in_word      in   WORD_W  word to scan; bit WORD_W-1 is streamed first
//  in_ready     out  1       controller can accept a word (IDLE only)
//  clear_ctx    in   1       clear detector history (effective in IDLE only)
//  det_bit      out  1       bit currently applied to the detector
//  det_valid    out  1       det_bit is valid this cycle (SHIFT only)
//  match_pulse  out  1       1-cycle pulse: the previous det bit completed PATTERN
//  match_count  out  CNT_W   matches in current/last word; held from DONE to next accept
//  busy         out  1       ~in_ready
//  done         out  1       1-cycle pulse; match_count final
//
// BEHAVIOUR
//  - Reset (async, any state): IDLE; shift reg, bit counter, history, fill count and
//    match_count = 0; in_ready = 1; det_valid, det_bit, match_pulse, done, busy = 0.
//  - FSM: IDLE -> SHIFT -> FLUSH -> DONE -> IDLE.
//    IDLE: in_ready = 1. If in_valid, latch in_word, set bit_cnt = WORD_W, clear
//      match_count, go to SHIFT.
//    SHIFT: det_valid = 1; det_bit = shreg MSB. Shift left on each edge. Decrement bit_cnt.
//      When bit_cnt reaches 1 on the edge, go to FLUSH. Length is exactly WORD_W cycles.
//    FLUSH: one cycle; the detector output for the last bit is visible; det_valid = 0.
//    DONE: one cycle; done = 1; go to IDLE.
//  - Handshake and throughput:
//    accept at edge k -> bits on cycles k+1..k+WORD_W -> FLUSH k+WORD_W+1 -> done k+WORD_W+2.
//    in_ready is low for WORD_W+2 cycles, so the maximum rate is one word per WORD_W+3 cycles.
//    in_valid held while busy is not lost; the word is accepted on the first IDLE cycle.
//  - Detector (Moore, overlapping):
//    history hist[PAT_W-1:0] <= {hist, det_bit} and fill <= min(fill+1, PAT_W), only when
//    det_valid. The Moore output is registered as match_pulse = (hist == PATTERN) &&
//    (fill == PAT_W) && "history advanced on the previous edge".
//    match_pulse therefore appears 1 cycle after the completing bit, in SHIFT or FLUSH.
//  - Counting: match_count += match_pulse, saturating at 2^CNT_W-1.
//  - Context: hist/fill persist across words, so matches spanning a word boundary are counted
//    in the later word. clear_ctx in IDLE zeroes hist/fill on that edge. If clear_ctx and
//    in_valid arrive together, the clear applies and the new word starts with empty history.
//    clear_ctx outside IDLE is ignored.
//  - Reset mid-word: the partial word is discarded, no done pulse is issued, and in_ready = 1
//    after reset is released.
//
// STRUCTURE
//  - Package stream_match_pkg: FSM state typedef (IDLE, SHIFT, FLUSH, DONE); default
//    PATTERN/PAT_W constants.
//  - Sub-module pattern_history_det (params PAT_W, PATTERN; ports clock, reset, clr, en,
//    bit_in, match): history/fill registers and registered Moore match. The controller holds
//    the FSM, shift register, bit counter and saturating counter.
//
// TESTING  (WORD_W=8, PAT_W=4, PATTERN=0010, CNT_W=4 unless stated)
//  1. Reset, send 8'b0010_0010: match_pulse 1 cycle after bit idx3 and bit idx7; done at
//     accept+10 cycles; match_count = 2.
//  2. Overlap, 8'b0010_0100: matches end at idx3 and idx6; match_count = 2.
//  3. Cross-word, 8'b1111_1100 then 8'b1011_1111 without clear: word1 count 0, word2 count 1
//     (pulse after word2 idx1). Repeat with clear_ctx with the second accept: word2 count 0.
//  4. Reset asserted after 3 SHIFT bits: all outputs 0 and in_ready = 1 immediately; no
//     done/match_pulse; the next word is counted from empty history.
//  5. CNT_W=1, 8'b0010_0010: match_count saturates at 1, no wrap to 0.
//  6. in_valid held high with a changing word during busy: next word is accepted only in the
//     IDLE cycle after done; scoreboard shows no loss or duplication of words.

Source files
------------

// File: rtl/stream_match_pkg.sv
// Shared types and defaults for the stream match controller and its pattern detector.
package stream_match_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int                   DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0010;

endpackage

// File: rtl/stream_match_ctrl_if.sv
// Word-input handshake between the word source and the stream match controller.
// A word transfers on a rising clock edge where in_valid and in_ready are both high;
// the source holds in_valid/in_word until then, and the sink may drop in_ready at any time.
interface stream_match_ctrl_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;

    modport master (output in_valid, output in_word, input in_ready);
    modport slave  (input in_valid, input in_word, output in_ready);
endinterface

// File: rtl/pattern_history_det.sv
// Moore pattern detector over a serial bit history; the match output decodes registers only.
module pattern_history_det
    import stream_match_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic              adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
            adv  <= 1'b0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            adv  <= 1'b0;
        end else begin
            adv <= en;
            if (en) begin
                hist <= {hist[PAT_W-2:0], bit_in};
                if (fill != FILL_FULL) fill <= fill + 1'b1;
            end
        end
    end

    // A match is only reported for the edge that actually advanced a full history.
    assign match = adv && (fill == FILL_FULL) && (hist == PATTERN);

endmodule

// File: rtl/stream_match_ctrl.sv
// Serialises accepted words MSB-first into the pattern detector and counts matches per word.
module stream_match_ctrl
    import stream_match_pkg::*;
#(
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    stream_match_ctrl_if.slave  in_if,
    input  logic                clear_ctx,
    output logic                det_bit,
    output logic                det_valid,
    output logic                match_pulse,
    output logic [CNT_W-1:0]    match_count,
    output logic                busy,
    output logic                done,
    output state_t              dbg_state
);

    localparam int                  BIT_CNT_W = $clog2(WORD_W + 1);
    localparam logic [BIT_CNT_W-1:0] BITS_FULL = BIT_CNT_W'(WORD_W);
    localparam logic [BIT_CNT_W-1:0] BITS_LAST = BIT_CNT_W'(1);

    state_t               state;
    logic [WORD_W-1:0]    shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 ready_r;
    logic                 det_clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
            ready_r     <= 1'b1;
            det_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (match_pulse && (match_count != {CNT_W{1'b1}}))
                match_count <= match_count + 1'b1;
            case (state)
                IDLE: begin
                    if (in_if.in_valid) begin
                        shreg       <= in_if.in_word;
                        bit_cnt     <= BITS_FULL;
                        match_count <= '0;
                        ready_r     <= 1'b0;
                        det_valid   <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == BITS_LAST) begin
                        det_valid <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                // The last bit's match decision is visible here, so the count settles on this edge.
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign det_bit        = det_valid & shreg[WORD_W-1];
    assign det_clr        = (state == IDLE) && clear_ctx;
    assign in_if.in_ready = ready_r;
    assign busy           = ~ready_r;
    assign dbg_state      = state;

    pattern_history_det #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_det (
        .clock  (clock),
        .reset  (reset),
        .clr    (det_clr),
        .en     (det_valid),
        .bit_in (det_bit),
        .match  (match_pulse)
    );

endmodule

// File: tb/tb_stream_match_ctrl.sv
// Bench for stream_match_ctrl: a default instance and a 1-bit-counter instance share all stimulus.
module tb_stream_match_ctrl;
    import stream_match_pkg::*;

    localparam int               WORD_W  = 8;
    localparam int               PAT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b0010;

    logic clock = 1'b0;
    logic reset;
    logic clear_ctx;
    always #5 clock = ~clock;

    stream_match_ctrl_if #(.WORD_W(WORD_W)) bus   ();
    stream_match_ctrl_if #(.WORD_W(WORD_W)) bus_s ();

    logic       det_bit, det_valid, match_pulse, busy, done;
    logic [3:0] match_count;
    state_t     dbg_state;
    logic       s_det_bit, s_det_valid, s_match_pulse, s_busy, s_done;
    logic [0:0] s_match_count;
    state_t     s_dbg_state;

    stream_match_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_if(bus.slave), .clear_ctx(clear_ctx),
        .det_bit(det_bit), .det_valid(det_valid), .match_pulse(match_pulse),
        .match_count(match_count), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    stream_match_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(1)) dut_sat (
        .clock(clock), .reset(reset), .in_if(bus_s.slave), .clear_ctx(clear_ctx),
        .det_bit(s_det_bit), .det_valid(s_det_valid), .match_pulse(s_match_pulse),
        .match_count(s_match_count), .busy(s_busy), .done(s_done), .dbg_state(s_dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic              hist_q[$];
    logic [WORD_W-1:0] exp_q[$];

    task automatic drive(input logic v, input logic [WORD_W-1:0] w, input logic c);
        bus.in_valid   = v;
        bus.in_word    = w;
        bus_s.in_valid = v;
        bus_s.in_word  = w;
        clear_ctx      = c;
    endtask

    // Driver plus cycle-by-cycle check of one word against the bit-history model.
    task automatic send_word(input string name, input logic [WORD_W-1:0] w, input logic clr,
                             input int exp_final);
        int t;
        int run;
        int e4, e1;
        bit flags[WORD_W];
        logic [PAT_W-1:0] win;
        logic e_v, e_b, e_p, e_d;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_wait: in_ready=%b after %0d cycles, want 1", name, bus.in_ready, t);
            return;
        end
        if (clr) hist_q.delete();
        for (int i = 0; i < WORD_W; i++) begin
            hist_q.push_back(w[WORD_W-1-i]);
            if (hist_q.size() > PAT_W) void'(hist_q.pop_front());
            flags[i] = 1'b0;
            if (hist_q.size() == PAT_W) begin
                for (int j = 0; j < PAT_W; j++) win[PAT_W-1-j] = hist_q[j];
                flags[i] = (win == PATTERN);
            end
        end
        drive(1'b1, w, clr);
        @(negedge clock);
        drive(1'b0, WORD_W'($urandom), 1'b0);
        run = 0;
        for (int c = 1; c <= WORD_W + 2; c++) begin
            e_v = (c <= WORD_W);
            e_b = (c <= WORD_W) ? w[WORD_W-c] : 1'b0;
            e_p = (c >= 2 && c <= WORD_W + 1) ? flags[c-2] : 1'b0;
            e_d = (c == WORD_W + 2);
            e4  = (run > 15) ? 15 : run;
            e1  = (run > 1) ? 1 : run;
            n_cmp++; if (det_valid !== e_v) begin n_err++; $display("FAIL %s c%0d det_valid: got %b want %b", name, c, det_valid, e_v); end
            n_cmp++; if (det_bit !== e_b) begin n_err++; $display("FAIL %s c%0d det_bit: got %b want %b", name, c, det_bit, e_b); end
            n_cmp++; if (match_pulse !== e_p) begin n_err++; $display("FAIL %s c%0d match_pulse: got %b want %b", name, c, match_pulse, e_p); end
            n_cmp++; if (done !== e_d) begin n_err++; $display("FAIL %s c%0d done: got %b want %b", name, c, done, e_d); end
            n_cmp++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s c%0d ready/busy: got %b/%b want 0/1", name, c, bus.in_ready, busy); end
            n_cmp++; if (match_count !== 4'(e4)) begin n_err++; $display("FAIL %s c%0d match_count: got %0d want %0d", name, c, match_count, e4); end
            n_cmp++; if (s_match_count !== 1'(e1)) begin n_err++; $display("FAIL %s c%0d sat match_count: got %0d want %0d", name, c, s_match_count, e1); end
            if (c == 1 || c == WORD_W + 1 || c == WORD_W + 2) begin
                n_cmp++;
                if (dbg_state !== ((c == 1) ? SHIFT : (c == WORD_W + 1) ? FLUSH : DONE)) begin
                    n_err++; $display("FAIL %s c%0d dbg_state: got %0d", name, c, dbg_state);
                end
            end
            if (c == WORD_W + 2 && exp_final >= 0) begin
                n_cmp++;
                if (match_count !== 4'(exp_final)) begin n_err++; $display("FAIL %s final_count: got %0d want %0d", name, match_count, exp_final); end
            end
            if (e_p) run++;
            if (c < WORD_W + 2) @(negedge clock);
        end
        e4 = (run > 15) ? 15 : run;
        e1 = (run > 1) ? 1 : run;
        @(negedge clock);
        n_cmp++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL %s idle_after: ready=%b done=%b want 1/0", name, bus.in_ready, done); end
        n_cmp++; if (match_count !== 4'(e4) || s_match_count !== 1'(e1)) begin n_err++; $display("FAIL %s count_held: got %0d/%0d want %0d/%0d", name, match_count, s_match_count, e4, e1); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset ready/busy: got %b/%b want 1/0", bus.in_ready, busy); end
        n_cmp++; if ({det_valid, det_bit, match_pulse, done} !== 4'b0) begin n_err++; $display("FAIL reset outputs: got %b want 0000", {det_valid, det_bit, match_pulse, done}); end
        n_cmp++; if (match_count !== 4'd0 || s_match_count !== 1'b0) begin n_err++; $display("FAIL reset count: got %0d/%0d want 0/0", match_count, s_match_count); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset state: got %0d want IDLE", dbg_state); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hist_q.delete();
        @(negedge clock);
        n_cmp++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL reset release: ready=%b done=%b want 1/0", bus.in_ready, done); end
    endtask

    task automatic test_basic();
        send_word("basic", 8'b0010_0010, 1'b0, 2);
    endtask

    task automatic test_overlap();
        send_word("overlap", 8'b0010_0100, 1'b1, 2);
    endtask

    task automatic test_cross_word();
        send_word("cross_w1", 8'b1111_1100, 1'b1, 0);
        send_word("cross_w2", 8'b1011_1111, 1'b0, 1);
        send_word("clr_w1", 8'b1111_1100, 1'b0, 0);
        send_word("clr_w2", 8'b1011_1111, 1'b1, 0);
    endtask

    task automatic test_fill_guard();
        send_word("fill_guard", 8'b0100_0000, 1'b1, 0);
    endtask

    task automatic test_saturation();
        send_word("saturate", 8'b0010_0010, 1'b1, 2);
    endtask

    task automatic test_mid_word_reset();
        send_word("rst_prep", 8'b1111_1100, 1'b1, 0);
        drive(1'b1, 8'b0011_1111, 1'b0);
        @(negedge clock);
        drive(1'b0, '0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL midrst ready/busy: got %b/%b want 1/0", bus.in_ready, busy); end
        n_cmp++; if ({det_valid, det_bit, match_pulse, done} !== 4'b0) begin n_err++; $display("FAIL midrst outputs: got %b want 0000", {det_valid, det_bit, match_pulse, done}); end
        n_cmp++; if (match_count !== 4'd0) begin n_err++; $display("FAIL midrst count: got %0d want 0", match_count); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hist_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++; if (done !== 1'b0 || match_pulse !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst quiet c%0d: done=%b pulse=%b ready=%b", i, done, match_pulse, bus.in_ready); end
        end
        send_word("rst_after", 8'b0111_1111, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            send_word("random", WORD_W'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), -1);
    endtask

    task automatic test_back_to_back();
        int sent, got, nb, last;
        logic [WORD_W-1:0] w, cur, ew;
        sent = 0; got = 0; nb = 0; last = 0; cur = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
            if (det_valid === 1'b1) begin
                cur = {cur[WORD_W-2:0], det_bit};
                nb++;
                if (nb == WORD_W) begin
                    nb = 0;
                    got++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL b2b extra_word: got %h with empty queue", cur);
                    end else begin
                        ew = exp_q.pop_front();
                        if (cur !== ew) begin n_err++; $display("FAIL b2b word: got %h want %h", cur, ew); end
                    end
                end
            end
            if (bus.in_ready === 1'b1 && sent < 5) begin
                w = WORD_W'($urandom);
                exp_q.push_back(w);
                drive(1'b1, w, 1'b0);
                if (sent > 0) begin
                    n_cmp++;
                    if (cyc - last != WORD_W + 3) begin n_err++; $display("FAIL b2b spacing: got %0d want %0d", cyc - last, WORD_W + 3); end
                end
                last = cyc;
                sent++;
            end else begin
                drive(sent < 5 && bus.in_ready !== 1'b1, WORD_W'($urandom), 1'b0);
            end
            @(negedge clock);
        end
        drive(1'b0, '0, 1'b0);
        n_cmp++; if (got != 5 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b totals: got %0d words, %0d left, want 5/0", got, exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_cross_word();
        test_fill_guard();
        test_saturation();
        test_mid_word_reset();
        test_random();
        test_back_to_back();
        repeat (4) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
